lcd_timing_gen: RTL and testbench
=================================

Name: lcd_timing_gen

Overview:
Parametrised LCD timing and panel-control generator for the video section. It produces dot/line counters, the PPU mode (OAM scan, transfer, hblank, vblank) and the panel pins CPL, FR, ST and S. Pixel transfer length stretches with pipeline stalls, and the block generates the LY=LYC coincidence and edge-detected STAT interrupt. It replaces fixed DMG-only line timing with configurable geometry and FR inversion period.

Parameters:
H_TOTAL, 456, dots per line
OAM_DOTS, 80, dots of mode 2 at start of each visible line
H_ACTIVE, 160, pixels pushed per visible line (mode 3 length without stalls)
V_ACTIVE, 144, visible lines
V_TOTAL, 154, total lines per frame
FR_LINES, 0, FR toggle period in lines; 0 = toggle once per frame
DOT_W, $clog2(H_TOTAL), dot counter width
LINE_W, $clog2(V_TOTAL), line counter width (must be ≤8 for LYC compare)

Ports:
clk  in  1  dot clock
reset_video  in  1  synchronous active-high reset
lcd_en  in  1  LCDC bit 7; 0 holds the block idle
pix_stall  in  1  pipe stall; freezes pixel push during mode 3
lyc  in  8  LYC register
irq_sel  in  4  STAT source enables: [0] hblank, [1] vblank, [2] OAM, [3] LYC
dot  out  DOT_W  current dot in line
ly  out  LINE_W  current line
mode  out  2  0 hblank, 1 vblank, 2 OAM, 3 transfer
pix_en  out  1  pixel pushed this cycle
coinc  out  1  ly == lyc
stat_irq  out  1  one-cycle STAT interrupt pulse
overrun  out  1  one-cycle pulse: mode 3 did not finish within the line
lcd_cpl  out  1  panel pixel clock
lcd_fr  out  1  panel polarity
lcd_st  out  1  panel line strobe
lcd_s  out  1  panel frame strobe

Behaviour:
- Synchronous reset, active-high. Reset has priority over lcd_en.
- Reset values: dot=0, ly=0, mode=0, pixel counter=0, and pix_en, coinc, stat_irq, overrun, lcd_cpl, lcd_fr, lcd_st, lcd_s all 0. The previous-STAT-line register is also cleared.
- lcd_en=0 has the same effect as reset on the next edge, including lcd_fr=0. It takes effect mid-line and mid-mode; there is no frame completion.
- After lcd_en rises, the first enabled edge sees dot=0, ly=0, mode=2.
- Counters, when enabled:
  - dot increments each clk and wraps at H_TOTAL-1 → 0.
  - On that wrap, ly increments and wraps at V_TOTAL-1 → 0.
- Mode, decoded from the registered state:
  - ly ≥ V_ACTIVE → 1.
  - Otherwise dot < OAM_DOTS → 2.
  - Then 3 until the pixel counter reaches H_ACTIVE, then 0 until end of line.
- Pixel counter:
  - Cleared at dot 0.
  - In mode 3, increments when pix_stall=0. pix_en = (mode==3 && !pix_stall), combinational from the current state.
  - The mode 3→0 transition occurs on the edge after the counter increments to H_ACTIVE.
  - Mode 3 therefore lasts H_ACTIVE + (stalled cycles) dots. Defaults with no stall: mode 3 at dots 80..239, mode 0 at 240..455.
- Overrun: if mode==3 at dot H_TOTAL-1, the line ends anyway and the pixel counter is cleared. overrun pulses for one cycle while dot=0 of the following line.
- lcd_cpl = pix_en registered (1-cycle latency, aligned with pixel data registered by the pipe).
- lcd_st is high for exactly one cycle, at dot 0 of each visible line (ly < V_ACTIVE).
- lcd_s is high for all dots of line 0.
- lcd_fr toggle timing:
  - FR_LINES=0: toggles on the edge entering ly=0, dot=0.
  - Otherwise: counts line wraps and toggles every FR_LINES wraps. The line counter is cleared at reset and disable, and is not realigned by frame wrap.
- coinc = (ly zero-extended == lyc), registered; valid one cycle after ly or lyc changes.
- STAT interrupt:
  - stat_line = (irq_sel[0] && mode==0) || (irq_sel[1] && mode==1) || (irq_sel[2] && mode==2) || (irq_sel[3] && coinc).
  - stat_irq pulses for one cycle on a 0→1 edge of stat_line. Sources overlapping in time produce no second pulse (STAT blocking).

Test Plan:
- Reset during mid-frame (ly=50, dot=300) → next cycle: all outputs 0, dot=0, ly=0; with lcd_en=1 after release, mode=2 at dot 0.
- One full frame, defaults, pix_stall=0:
  - Mode 2 at dots 0..79, mode 3 at 80..239 (160 pix_en), mode 0 at 240..455 on lines 0..143.
  - Mode 1 from ly=144 dot 0 to ly=153 dot 455.
  - lcd_st 144 pulses; lcd_s high for 456 cycles; lcd_fr toggles once per frame.
- pix_stall high for 12 cycles inside mode 3 → mode 3 spans dots 80..251, mode 0 starts at dot 252, 160 pix_en total. lcd_cpl lags pix_en by one cycle.
- lyc=0x45, irq_sel=4'b1000 → coinc=1 during ly=69 (one cycle late), single stat_irq pulse. irq_sel=4'b1001 → one pulse at ly=69 mode 3→0 only if coinc rose first; no double pulse.
- pix_stall held high through the whole line → mode 3 from dot 80 to 455, overrun pulse at next line dot 0, ly increments normally.
- FR_LINES=13 → lcd_fr toggles every 13 line wraps regardless of frame boundary. lcd_en dropped at ly=100 → lcd_fr=0 and counters 0 next cycle.

Source files
------------

// File: rtl/lcd_timing_gen.sv
// ---------------------------------------------------------------------------
// lcd_timing_gen
//
// LCD timing and panel-control generator for the video section.
// It tracks the dot and line position, decodes the PPU mode, stretches
// pixel transfer while the pixel pipe stalls, and drives the panel pins.
// It also produces the LY==LYC coincidence flag and the edge-detected STAT
// interrupt.
//
// Ports
//   clk          dot clock
//   reset_video  synchronous active-high reset (has priority over lcd_en)
//   lcd_en       LCDC bit 7; 0 holds the block idle (same effect as reset)
//   pix_stall    pixel pipe stall; freezes pixel push during transfer
//   lyc          LYC register
//   irq_sel      STAT enables: [0] hblank, [1] vblank, [2] OAM, [3] LYC
//   dot          current dot within the line
//   ly           current line
//   mode         0 hblank, 1 vblank, 2 OAM scan, 3 transfer
//   pix_en       a pixel is pushed this cycle
//   coinc        registered ly == lyc
//   stat_irq     one-cycle STAT interrupt pulse
//   overrun      one-cycle pulse at dot 0 after a line ended still in mode 3
//   lcd_cpl      panel pixel clock (pix_en delayed one cycle)
//   lcd_fr       panel polarity
//   lcd_st       panel line strobe, dot 0 of each visible line
//   lcd_s        panel frame strobe, high for all of line 0
// ---------------------------------------------------------------------------
module lcd_timing_gen #(
    parameter int H_TOTAL  = 456,
    parameter int OAM_DOTS = 80,
    parameter int H_ACTIVE = 160,
    parameter int V_ACTIVE = 144,
    parameter int V_TOTAL  = 154,
    parameter int FR_LINES = 0,
    parameter int DOT_W    = $clog2(H_TOTAL),
    parameter int LINE_W   = $clog2(V_TOTAL)
) (
    input  logic              clk,
    input  logic              reset_video,
    input  logic              lcd_en,
    input  logic              pix_stall,
    input  logic [7:0]        lyc,
    input  logic [3:0]        irq_sel,
    output logic [DOT_W-1:0]  dot,
    output logic [LINE_W-1:0] ly,
    output logic [1:0]        mode,
    output logic              pix_en,
    output logic              coinc,
    output logic              stat_irq,
    output logic              overrun,
    output logic              lcd_cpl,
    output logic              lcd_fr,
    output logic              lcd_st,
    output logic              lcd_s
);

    localparam int PIX_W = $clog2(H_ACTIVE + 1);
    localparam int FRC_W = (FR_LINES > 1) ? $clog2(FR_LINES) : 1;

    typedef enum logic [1:0] {
        MODE_HBLANK = 2'd0,
        MODE_VBLANK = 2'd1,
        MODE_OAM    = 2'd2,
        MODE_XFER   = 2'd3
    } mode_t;

    // run is low while idle; the first enabled edge only raises it, so the
    // block comes out of idle at dot 0, line 0 in OAM scan.
    logic              run;
    logic [PIX_W-1:0]  pix_cnt;
    logic [FRC_W-1:0]  fr_cnt;
    logic              stat_prev;

    mode_t             mode_cur;
    logic              line_end;
    logic              frame_end;
    logic [DOT_W-1:0]  nxt_dot;
    logic [LINE_W-1:0] nxt_ly;
    logic              stat_line;

    assign line_end  = (dot == DOT_W'(H_TOTAL - 1));
    assign frame_end = line_end && (ly == LINE_W'(V_TOTAL - 1));

    // Mode is decoded from the registered position and pixel count, so the
    // transfer phase ends in the same cycle the pixel count reaches H_ACTIVE.
    always_comb begin
        mode_cur = MODE_HBLANK;
        if (!run)
            mode_cur = MODE_HBLANK;
        else if (ly >= LINE_W'(V_ACTIVE))
            mode_cur = MODE_VBLANK;
        else if (dot < DOT_W'(OAM_DOTS))
            mode_cur = MODE_OAM;
        else if (pix_cnt < PIX_W'(H_ACTIVE))
            mode_cur = MODE_XFER;
        else
            mode_cur = MODE_HBLANK;
    end

    assign mode   = mode_cur;
    assign pix_en = (mode_cur == MODE_XFER) && !pix_stall;

    // Next position; held at the origin on the edge that leaves idle.
    always_comb begin
        nxt_dot = '0;
        nxt_ly  = '0;
        if (run) begin
            if (line_end) begin
                nxt_dot = '0;
                nxt_ly  = frame_end ? '0 : ly + 1'b1;
            end else begin
                nxt_dot = dot + 1'b1;
                nxt_ly  = ly;
            end
        end
    end

    always_comb begin
        stat_line = 1'b0;
        if (run)
            stat_line = (irq_sel[0] && mode_cur == MODE_HBLANK) ||
                        (irq_sel[1] && mode_cur == MODE_VBLANK) ||
                        (irq_sel[2] && mode_cur == MODE_OAM)    ||
                        (irq_sel[3] && coinc);
    end

    always_ff @(posedge clk) begin
        if (reset_video || !lcd_en) begin
            run       <= 1'b0;
            dot       <= '0;
            ly        <= '0;
            pix_cnt   <= '0;
            fr_cnt    <= '0;
            stat_prev <= 1'b0;
            coinc     <= 1'b0;
            stat_irq  <= 1'b0;
            overrun   <= 1'b0;
            lcd_cpl   <= 1'b0;
            lcd_fr    <= 1'b0;
            lcd_st    <= 1'b0;
            lcd_s     <= 1'b0;
        end else begin
            run <= 1'b1;
            dot <= nxt_dot;
            ly  <= nxt_ly;

            // A line that ends still in transfer is cut short; the count
            // restarts with the next line either way.
            if (line_end)
                pix_cnt <= '0;
            else if (pix_en)
                pix_cnt <= pix_cnt + 1'b1;

            overrun <= line_end && (mode_cur == MODE_XFER);
            lcd_cpl <= pix_en;
            lcd_st  <= (nxt_dot == '0) && (nxt_ly < LINE_W'(V_ACTIVE));
            lcd_s   <= (nxt_ly == '0);

            coinc     <= (8'(ly) == lyc);
            stat_prev <= stat_line;
            stat_irq  <= stat_line && !stat_prev;

            // FR: once per frame, or every FR_LINES line wraps with a free
            // running counter that ignores frame boundaries.
            if (FR_LINES == 0) begin
                if (run && frame_end)
                    lcd_fr <= ~lcd_fr;
            end else if (run && line_end) begin
                if (fr_cnt == FRC_W'(FR_LINES - 1)) begin
                    fr_cnt <= '0;
                    lcd_fr <= ~lcd_fr;
                end else begin
                    fr_cnt <= fr_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_lcd_timing_gen.sv
module tb_lcd_timing_gen;

    logic       clk = 1'b0;
    logic       reset_video;
    logic       lcd_en;
    logic       pix_stall;
    logic [7:0] lyc;
    logic [3:0] irq_sel;

    // default-geometry instance (FR once per frame)
    logic [8:0] a_dot;
    logic [7:0] a_ly;
    logic [1:0] a_mode;
    logic a_pix, a_coinc, a_irq, a_ovr, a_cpl, a_fr, a_st, a_s;
    // FR_LINES=13 instance, same stimulus
    logic [8:0] b_dot;
    logic [7:0] b_ly;
    logic [1:0] b_mode;
    logic b_pix, b_coinc, b_irq, b_ovr, b_cpl, b_fr, b_st, b_s;

    lcd_timing_gen u_a (
        .clk(clk), .reset_video(reset_video), .lcd_en(lcd_en),
        .pix_stall(pix_stall), .lyc(lyc), .irq_sel(irq_sel),
        .dot(a_dot), .ly(a_ly), .mode(a_mode), .pix_en(a_pix),
        .coinc(a_coinc), .stat_irq(a_irq), .overrun(a_ovr),
        .lcd_cpl(a_cpl), .lcd_fr(a_fr), .lcd_st(a_st), .lcd_s(a_s)
    );

    lcd_timing_gen #(.FR_LINES(13)) u_b (
        .clk(clk), .reset_video(reset_video), .lcd_en(lcd_en),
        .pix_stall(pix_stall), .lyc(lyc), .irq_sel(irq_sel),
        .dot(b_dot), .ly(b_ly), .mode(b_mode), .pix_en(b_pix),
        .coinc(b_coinc), .stat_irq(b_irq), .overrun(b_ovr),
        .lcd_cpl(b_cpl), .lcd_fr(b_fr), .lcd_st(b_st), .lcd_s(b_s)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic rst;
        logic en;
        int   cyc;
        int   dot;
        int   ly;
        int   mode;
        int   pix;
    } vec_t;

    vec_t vt[9];

    int e_ly, e_dot;

    task automatic advance();
        if (e_dot == 455) begin
            e_dot = 0;
            e_ly  = (e_ly == 153) ? 0 : e_ly + 1;
        end else begin
            e_dot = e_dot + 1;
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " dot"},    a_dot,   0);
        check({tag, " ly"},     a_ly,    0);
        check({tag, " mode"},   a_mode,  0);
        check({tag, " pix_en"}, a_pix,   0);
        check({tag, " coinc"},  a_coinc, 0);
        check({tag, " irq"},    a_irq,   0);
        check({tag, " ovr"},    a_ovr,   0);
        check({tag, " cpl"},    a_cpl,   0);
        check({tag, " fr"},     a_fr,    0);
        check({tag, " fr13"},   b_fr,    0);
        check({tag, " st"},     a_st,    0);
        check({tag, " s"},      a_s,     0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: time limit reached, got no end, expected finish");
        $fatal(1);
    end

    initial begin
        int err_pos, err_mode, err_pix, err_cpl, err_st, err_s, err_ovr;
        int err_coinc, err_irq, err_fr, err_fr13;
        int n_st, n_s, n_irq, pix10, pix20, end3, em;
        logic stall, ep, prev_ep, noted;
        int win_irq;

        reset_video = 1'b1;
        lcd_en      = 1'b0;
        pix_stall   = 1'b0;
        lyc         = 8'h45;
        irq_sel     = 4'b1000;

        // rst, en, cycles, dot, ly, mode, pix_en
        vt[0] = '{1'b1, 1'b1,   2,   0, 0, 0, 0};
        vt[1] = '{1'b0, 1'b0,   3,   0, 0, 0, 0};
        vt[2] = '{1'b0, 1'b1,   1,   0, 0, 2, 0};
        vt[3] = '{1'b0, 1'b1,  79,  79, 0, 2, 0};
        vt[4] = '{1'b0, 1'b1,   1,  80, 0, 3, 1};
        vt[5] = '{1'b0, 1'b1, 159, 239, 0, 3, 1};
        vt[6] = '{1'b0, 1'b1,   1, 240, 0, 0, 0};
        vt[7] = '{1'b0, 1'b1, 215, 455, 0, 0, 0};
        vt[8] = '{1'b0, 1'b1,   1,   0, 1, 2, 0};

        for (int i = 0; i < 9; i++) begin
            reset_video = vt[i].rst;
            lcd_en      = vt[i].en;
            repeat (vt[i].cyc) tick();
            check($sformatf("vec%0d dot", i),    a_dot,  vt[i].dot);
            check($sformatf("vec%0d ly", i),     a_ly,   vt[i].ly);
            check($sformatf("vec%0d mode", i),   a_mode, vt[i].mode);
            check($sformatf("vec%0d pix_en", i), a_pix,  vt[i].pix);
            if (i == 0) check_idle("reset");
        end

        // ---- one full frame with a short stall (line 10) and a
        //      whole-line stall (line 20) ----
        reset_video = 1'b1;
        tick();
        reset_video = 1'b0;
        lcd_en      = 1'b1;
        tick();
        e_ly = 0; e_dot = 0; prev_ep = 1'b0; noted = 1'b0;
        err_pos = 0; err_mode = 0; err_pix = 0; err_cpl = 0; err_st = 0;
        err_s = 0; err_ovr = 0; err_coinc = 0; err_irq = 0; err_fr = 0;
        err_fr13 = 0; n_st = 0; n_s = 0; n_irq = 0; pix10 = 0; pix20 = 0;

        for (int i = 0; i < 154 * 456; i++) begin
            stall = (e_ly == 10 && e_dot >= 100 && e_dot <= 111) || (e_ly == 20);
            pix_stall = stall;
            #1;
            end3 = (e_ly == 10) ? 252 : (e_ly == 20) ? 456 : 240;
            em   = (e_ly >= 144) ? 1 : (e_dot < 80) ? 2 : (e_dot < end3) ? 3 : 0;
            ep   = (em == 3) && !stall;
            if (a_dot != e_dot || a_ly != e_ly) err_pos++;
            if (a_mode != em) err_mode++;
            if (a_pix != ep) err_pix++;
            if (a_cpl != prev_ep) err_cpl++;
            if (a_st != (e_dot == 0 && e_ly < 144)) err_st++;
            if (a_s != (e_ly == 0)) err_s++;
            if (a_ovr != (e_ly == 21 && e_dot == 0)) err_ovr++;
            if (a_coinc != ((e_ly == 69 && e_dot >= 1) || (e_ly == 70 && e_dot == 0))) err_coinc++;
            if (a_irq != (e_ly == 69 && e_dot == 2)) err_irq++;
            if (a_fr != 1'b0) err_fr++;
            if (b_fr != (((e_ly / 13) % 2) == 1)) err_fr13++;
            if (!noted && (a_mode != em || a_dot != e_dot || a_ly != e_ly)) begin
                noted = 1'b1;
                $display("first divergence at ly %0d dot %0d", e_ly, e_dot);
            end
            n_st  += a_st;
            n_s   += a_s;
            n_irq += a_irq;
            if (e_ly == 10) pix10 += a_pix;
            if (e_ly == 20) pix20 += a_pix;
            prev_ep = ep;
            tick();
            advance();
        end
        pix_stall = 1'b0;

        check("frame position errors", err_pos, 0);
        check("frame mode errors", err_mode, 0);
        check("frame pix_en errors", err_pix, 0);
        check("frame cpl lag errors", err_cpl, 0);
        check("frame st errors", err_st, 0);
        check("frame s errors", err_s, 0);
        check("frame overrun errors", err_ovr, 0);
        check("frame coinc errors", err_coinc, 0);
        check("frame irq errors", err_irq, 0);
        check("frame fr errors", err_fr, 0);
        check("frame fr13 errors", err_fr13, 0);
        check("st pulse count", n_st, 144);
        check("s high cycles", n_s, 456);
        check("lyc irq pulses", n_irq, 1);
        check("stalled line pixels", pix10, 160);
        check("overrun line pixels", pix20, 0);
        check("frame2 ly", a_ly, 0);
        check("fr after frame", a_fr, 1);
        check("fr13 after frame", b_fr, 1);

        // ---- second frame: FR_LINES carry-over, STAT blocking ----
        lyc     = 8'd3;
        irq_sel = 4'b1001;
        win_irq = 0;
        while (!(e_ly == 5 && e_dot == 100) && e_ly < 6) begin
            if (e_ly == 1 && e_dot == 0) check("fr13 ly1", b_fr, 1);
            if (e_ly == 2 && e_dot == 0) check("fr13 ly2", b_fr, 0);
            if (e_ly == 3 && e_dot == 0) check("coinc ly3 dot0", a_coinc, 0);
            if (e_ly == 3 && e_dot == 1) check("coinc ly3 dot1", a_coinc, 1);
            if (e_ly == 2 && e_dot == 241) check("irq hblank ly2", a_irq, 1);
            if (e_ly == 3 && e_dot == 2) check("irq lyc ly3", a_irq, 1);
            if (e_ly == 3 && e_dot == 241) check("irq blocked ly3", a_irq, 0);
            if (e_ly == 4 && e_dot == 241) check("irq hblank ly4", a_irq, 1);
            if (e_ly >= 2 && e_ly <= 4) win_irq += a_irq;
            tick();
            advance();
        end
        check("irq pulses ly2..4", win_irq, 3);
        check("pre-disable ly", a_ly, 5);
        check("pre-disable fr", a_fr, 1);

        // ---- mid-line disable ----
        lcd_en = 1'b0;
        tick();
        check_idle("disable");
        lcd_en = 1'b1;
        tick();
        check("reenable mode", a_mode, 2);
        check("reenable dot", a_dot, 0);
        e_ly = 0; e_dot = 0;

        // ---- mid-frame reset ----
        repeat (2 * 456 + 300) tick();
        check("pre-reset ly", a_ly, 2);
        check("pre-reset dot", a_dot, 300);
        reset_video = 1'b1;
        tick();
        check_idle("midreset");
        reset_video = 1'b0;
        tick();
        check("post-reset mode", a_mode, 2);
        check("post-reset dot", a_dot, 0);
        check("post-reset ly", a_ly, 0);
        check("post-reset st", a_st, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
